// File: rtl/freq_meter.sv
// Gated frequency counter: counts hysteresis-qualified rising crossings of the ADC
// stream over a fixed gate and publishes the count with a one-cycle done strobe.
module freq_meter #(
  parameter int DATA_W      = 12,
  parameter int GATE_CYCLES = 50000000,
  parameter int HYST        = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              run_stop,
  output logic [31:0]       freq_out,
  output logic              measure_done,
  output logic              overflow,
  output logic              busy
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES + 1) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DATA_W:0]   HYST_EXT  = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0]   DATA_MAX  = {1'b0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LATCH} state_t;
  typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} level_t;

  state_t            state, state_next;
  level_t            level, level_next;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_next;
  logic              sat, sat_next;
  logic [DATA_W:0]   trig_ext, sample_ext, lo_ext, hi_ext, hi_sum;
  logic              is_low, is_high, gate_end;

  // Thresholds are computed one bit wider so they clamp instead of wrapping.
  always_comb begin
    trig_ext   = {1'b0, trig_level};
    sample_ext = {1'b0, sample};
    hi_sum     = trig_ext + HYST_EXT;
    lo_ext     = (trig_ext > HYST_EXT) ? (trig_ext - HYST_EXT) : '0;
    hi_ext     = (hi_sum > DATA_MAX) ? DATA_MAX : hi_sum;
    is_low     = (sample_ext <= lo_ext);
    is_high    = (sample_ext >= hi_ext);
  end

  assign gate_end = (state == MEASURE) && (gate_cnt == GATE_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!run_stop) state_next = ARM;
      ARM:     state_next = MEASURE;
      MEASURE: if (gate_end) state_next = LATCH;
      LATCH:   state_next = ARM;
      default: state_next = IDLE;
    endcase
    if (run_stop) state_next = IDLE;
  end

  // A rise is only counted from a confirmed LOW; the first HIGH after ARM is not an edge.
  always_comb begin
    level_next    = level;
    edge_cnt_next = edge_cnt;
    sat_next      = sat;
    if (state == ARM) begin
      level_next    = LVL_UNKNOWN;
      edge_cnt_next = '0;
      sat_next      = 1'b0;
    end else if (state == MEASURE && sample_valid) begin
      if (is_low) begin
        level_next = LVL_LOW;
      end else if (is_high) begin
        level_next = LVL_HIGH;
        if (level == LVL_LOW) begin
          if (edge_cnt == CNT_MAX) sat_next = 1'b1;
          else edge_cnt_next = edge_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      level        <= LVL_UNKNOWN;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      sat          <= 1'b0;
      freq_out     <= '0;
      overflow     <= 1'b0;
      measure_done <= 1'b0;
    end else begin
      state        <= state_next;
      level        <= level_next;
      edge_cnt     <= edge_cnt_next;
      sat          <= sat_next;
      gate_cnt     <= (state == MEASURE) ? gate_cnt + GATE_W'(1) : '0;
      measure_done <= 1'b0;
      // Results are captured with the final cycle's edge included, visible during LATCH.
      if (gate_end && state_next == LATCH) begin
        freq_out     <= 32'(edge_cnt_next);
        overflow     <= sat_next;
        measure_done <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a gate-window reference model checked every cycle against two
// instances (32-bit and 4-bit edge counters), plus directed literal expectations.
module tb_freq_meter;

  localparam int G  = 100;
  localparam int HY = 16;

  logic        clk = 1'b0;
  logic        rst, sample_valid, run_stop;
  logic [11:0] sample, trig_level;
  logic [31:0] freq_a, freq_b;
  logic        done_a, done_b, ovf_a, ovf_b, busy_a, busy_b;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  bit          running = 1'b0;
  int          pos = 0;
  int          q_s[$], q_lo[$], q_hi[$];
  bit [31:0]   e_freq32 = 0, e_freq4 = 0;
  bit          e_ovf32 = 0, e_ovf4 = 0, e_done = 0;

  // Stimulus controls
  int mode = 1, period = 10, tog_a = 0, tog_b = 0;

  freq_meter #(.DATA_W(12), .GATE_CYCLES(G), .HYST(HY), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .run_stop(run_stop), .freq_out(freq_a),
    .measure_done(done_a), .overflow(ovf_a), .busy(busy_a));

  freq_meter #(.DATA_W(12), .GATE_CYCLES(G), .HYST(HY), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .run_stop(run_stop), .freq_out(freq_b),
    .measure_done(done_b), .overflow(ovf_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lo_of(input int t);
    return (t - HY < 0) ? 0 : t - HY;
  endfunction

  function automatic int hi_of(input int t);
    return (t + HY > 4095) ? 4095 : t + HY;
  endfunction

  // Counts LOW->HIGH transitions over the valid samples recorded in one gate window.
  function automatic int count_rises();
    int lvl = 0;
    int n = 0;
    foreach (q_s[i]) begin
      if (q_s[i] <= q_lo[i]) lvl = 1;
      else if (q_s[i] >= q_hi[i]) begin
        if (lvl == 1) n++;
        lvl = 2;
      end
    end
    return n;
  endfunction

  // pos: 0 = arming cycle, 1..G = gate cycles, G+1 = result cycle
  always @(posedge clk) begin
    int raw;
    if (rst) begin
      running = 1'b0; pos = 0; e_done = 1'b0;
      e_freq32 = 0; e_freq4 = 0; e_ovf32 = 1'b0; e_ovf4 = 1'b0;
      q_s.delete(); q_lo.delete(); q_hi.delete();
    end else begin
      e_done = 1'b0;
      if (run_stop) running = 1'b0;
      else if (!running) begin running = 1'b1; pos = 0; end
      else if (pos == 0) begin
        q_s.delete(); q_lo.delete(); q_hi.delete();
        pos = 1;
      end else if (pos <= G) begin
        if (sample_valid) begin
          q_s.push_back(int'(sample));
          q_lo.push_back(lo_of(int'(trig_level)));
          q_hi.push_back(hi_of(int'(trig_level)));
        end
        if (pos == G) begin
          raw      = count_rises();
          e_freq32 = raw;
          e_ovf32  = 1'b0;
          e_freq4  = (raw > 15) ? 15 : raw;
          e_ovf4   = (raw > 15);
          e_done   = 1'b1;
        end
        pos++;
      end else pos = 0;
    end
  end

  always @(negedge clk) begin
    check_output("busy", busy_a, running);
    check_output("busy_w4", busy_b, running);
    check_output("done", done_a, e_done);
    check_output("done_w4", done_b, e_done);
    check_output("freq", freq_a, e_freq32);
    check_output("freq_w4", freq_b, e_freq4);
    check_output("ovf", ovf_a, e_ovf32);
    check_output("ovf_w4", ovf_b, e_ovf4);
  end

  // Waveforms are phased to the gate so every window sees the same pattern.
  initial begin
    int m;
    sample = '0;
    sample_valid = 1'b0;
    forever begin
      @(negedge clk);
      m = (pos >= 1) ? pos - 1 : 0;
      sample_valid = 1'b1;
      case (mode)
        0: sample = 12'd0;
        1: sample = ((m % period) < period / 2) ? 12'd0 : 12'd4095;
        2: sample = (m % 2 == 1) ? 12'(tog_b) : 12'(tog_a);
        default: begin
          sample_valid = (m % 2 == 0);
          sample = ((m % 20) < 10) ? 12'd0 : 12'd4095;
          if (!sample_valid) sample = ~sample;
        end
      endcase
    end
  end

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done_a && cycles < limit);
    checks++;
    if (!done_a) begin
      fails++;
      $display("[TB] FAIL done_timeout: no strobe within %0d cycles, expected one", limit);
    end
  endtask

  task automatic apply_stimulus(input int md, input int trig, input int a, input int b,
                                input string name, input int exp_freq);
    int c;
    mode = md; trig_level = 12'(trig); tog_a = a; tog_b = b;
    wait_done(300, c);
    check_output(name, freq_a, exp_freq);
  endtask

  initial begin
    int c;
    rst = 1'b1; run_stop = 1'b0; trig_level = 12'd2048;
    mode = 1; period = 10;
    repeat (3) @(negedge clk);
    check_output("rst_freq", freq_a, 0);
    check_output("rst_busy", busy_a, 0);
    check_output("rst_done", done_a, 0);
    check_output("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("busy_after_rst", busy_a, 1);

    wait_done(300, c);
    check_output("square10_freq", freq_a, 10);
    check_output("square10_ovf", ovf_a, 0);
    wait_done(300, c);
    check_output("strobe_period", c, 102);

    apply_stimulus(2, 2048, 2040, 2056, "inside_band", 0);
    apply_stimulus(2, 2048, 2032, 2064, "band_edges", 50);
    apply_stimulus(2, 5, 0, 21, "clamp_low", 50);
    apply_stimulus(2, 5, 1, 20, "clamp_low_inside", 0);
    apply_stimulus(2, 4090, 4074, 4094, "clamp_high_inside", 0);
    apply_stimulus(2, 4090, 4074, 4095, "clamp_high", 50);
    apply_stimulus(1, 2048, 0, 0, "square10_again", 10);

    repeat (51) @(negedge clk);
    run_stop = 1'b1;
    @(negedge clk);
    check_output("stop_busy", busy_a, 0);
    repeat (10) begin
      @(negedge clk);
      check_output("stop_hold_freq", freq_a, 10);
      check_output("stop_no_done", done_a, 0);
    end
    run_stop = 1'b0;
    wait_done(300, c);
    check_output("restart_latency", c, 102);
    check_output("restart_freq", freq_a, 10);

    apply_stimulus(3, 2048, 0, 0, "half_valid", 5);

    period = 4;
    apply_stimulus(1, 2048, 0, 0, "square4_w32", 25);
    check_output("square4_w4", freq_b, 15);
    check_output("square4_ovf_w4", ovf_b, 1);
    check_output("square4_ovf_w32", ovf_a, 0);
    apply_stimulus(0, 2048, 0, 0, "flat_w32", 0);
    check_output("flat_w4", freq_b, 0);
    check_output("flat_ovf_w4", ovf_b, 0);

    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midgate_rst_busy", busy_a, 0);
    check_output("midgate_rst_freq", freq_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
